str_line_sched: RTL and testbench
=================================

// Module: str_line_sched
// PURPOSE
//   Shares one 16-character display line between N_REQ requesters, each offering a
//   128-bit ASCII string (byte i = character position i, as produced by the
//   binary-to-string converters).
//   A round-robin arbiter grants one requester and latches its string. The block
//   then streams the string one character at a time, with valid/ready, to the
//   character-LCD write driver.
// PARAMETERS
//   N_REQ  2   number of string requesters (1..8)
//   LEN    16  characters sent per string (1..16); bytes >= LEN are never sent
// PORTS
//   CLK       in   1          system clock, all state on rising edge
//   RST       in   1          asynchronous, active-high reset
//   req       in   N_REQ      level request per requester; sampled only in IDLE
//   str_in    in   N_REQ*128  strings; requester k uses str_in[128*k+:128]; stable while req
//   gnt       out  N_REQ      one-hot, 1-cycle pulse: string k latched
//   busy      out  1          high in any state other than IDLE
//   ch_data   out  8          ASCII character
//   ch_addr   out  4          line position of ch_data (0..LEN-1)
//   ch_valid  out  1          character offered
//   ch_ready  in   1          driver accepts when ch_valid && ch_ready
//   done      out  1          1-cycle pulse: string finished
// BEHAVIOUR
//   - Reset (async): state=IDLE, idx=0, last_gnt=N_REQ-1, buf=0; all outputs 0.
//     A reset mid-transfer aborts it with no done pulse.
//   - FSM: IDLE -> SEND -> DONE -> IDLE. All outputs are registered.
//   - IDLE, req!=0: search starts at (last_gnt+1) mod N_REQ, first set bit wins.
//     On the next edge: buf<=str_in[winner], gnt<=onehot(winner), last_gnt<=winner,
//     idx<=0, state<=SEND.
//   - SEND: ch_valid=1, ch_data=buf[8*idx+:8], ch_addr=idx.
//     - Data, addr and valid are held until the handshake; valid never drops
//       without acceptance.
//     - On accept: if idx==LEN-1, go to DONE, else idx++. Throughput is 1 char/clk
//       with ch_ready=1.
//   - DONE: done=1 for exactly 1 cycle, then IDLE. With req held and ch_ready=1,
//     next gnt comes 2 cycles after done.
//   - Latency with ch_ready=1: req seen in IDLE -> gnt next cycle, ch_valid from that
//     same cycle, LEN beats, done the cycle after the last beat.
//   - req changes outside IDLE are ignored; a dropped req loses its turn.
//     N_REQ=1 grants req[0] every time.
// CONFIGURATION
//   STR_LINE_SCHED_SKIP_EN defined:
//     - Adds shadow last[127:0] and last_ok flag (both 0 on reset).
//     - In SEND, if last_ok && buf byte == last byte at idx: no ch_valid, idx
//       advances one per cycle (end rule as for accept).
//     - Each accepted char is written into last. last_ok=1 after the first
//       completed string.
//     - done still pulses even if every character was skipped.
//   Undefined: all LEN characters always sent; no shadow storage.
// TESTING
//   1 RST=1 mid-stream -> gnt, busy, ch_valid, done, ch_data, ch_addr all 0 in the
//     same cycle; after release, busy=0.
//   2 req=2'b01, str_in[127:0]="0000000000000101", ch_ready=1 -> gnt=01 one cycle,
//     16 beats addr 0..15, byte0=8'h31, done 1 cycle after addr 15.
//   3 As 2 with ch_ready=0 for 3 cycles at addr 5 -> ch_data/ch_addr/ch_valid held,
//     total beats still 16, no duplicated addr.
//   4 req=2'b11 held, ch_ready=1 -> gnt sequence 01,10,01,10; each string complete
//     before the next gnt.
//   5 RST pulsed at addr 7 of requester 1, then req=2'b11 -> first gnt=01, stream
//     restarts at addr 0.
//   6 (SKIP_EN) send "................" twice, second time byte 3 = "1" -> second
//     pass exactly one beat (addr 3, 8'h31), then done.

Source files
------------

// File: rtl/str_line_sched.sv
// str_line_sched: round-robin sharing of one 16-character display line.
// A requester is granted, its 128-bit ASCII string is latched, and the characters
// are streamed one per beat (valid/ready) to the character-LCD write driver.
// Optional build macro STR_LINE_SCHED_SKIP_EN: keeps a shadow of the characters
// last written to the line and skips positions whose character is unchanged.
module str_line_sched #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned LEN   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*128-1:0] str_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic [7:0]         ch_data,
  output logic [3:0]         ch_addr,
  output logic               ch_valid,
  input  logic               ch_ready,
  output logic               done
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [GW-1:0]  last_gnt_q, last_gnt_d;
  logic [127:0]   str_q, str_d;

  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [7:0]       ch_data_q, ch_data_d;
  logic [3:0]       ch_addr_q, ch_addr_d;
  logic             ch_valid_q, ch_valid_d;
  logic             done_q, done_d;

  logic             req_hit;
  logic [GW-1:0]    winner;
  logic             adv;
  logic             last_beat;

`ifdef STR_LINE_SCHED_SKIP_EN
  logic [127:0]     last_q;
  logic             last_ok_q;
`endif

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign ch_data  = ch_data_q;
  assign ch_addr  = ch_addr_q;
  assign ch_valid = ch_valid_q;
  assign done     = done_q;

  // Round-robin search: start one past the last grant, first requesting index wins.
  always_comb begin
    int unsigned k;
    req_hit = 1'b0;
    winner  = '0;
    k       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(last_gnt_q) + 32'd1 + i) % N_REQ;
      if (!req_hit && req[k[GW-1:0]]) begin
        req_hit = 1'b1;
        winner  = k[GW-1:0];
      end
    end
  end

  // Position advances on a handshake, or every cycle while a position is skipped.
`ifdef STR_LINE_SCHED_SKIP_EN
  assign adv = ch_ready || !ch_valid_q;
`else
  assign adv = ch_ready;
`endif
  assign last_beat = (idx_q == 4'(LEN - 1));

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      last_gnt_q <= GW'(N_REQ - 1);
      str_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_gnt_q <= last_gnt_d;
      str_q      <= str_d;
    end
  end

  // Next-state logic: grant in IDLE, step through positions in SEND, one DONE cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_gnt_d = last_gnt_q;
    str_d      = str_q;
    unique case (state_q)
      StIdle: begin
        if (req_hit) begin
          str_d      = str_in[128*32'(winner) +: 128];
          last_gnt_d = winner;
          idx_d      = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (adv) begin
          if (last_beat) state_d = StDone;
          else           idx_d   = idx_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the next state.
  always_comb begin
    gnt_d      = '0;
    ch_data_d  = '0;
    ch_addr_d  = '0;
    ch_valid_d = 1'b0;
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    if (state_q == StIdle && req_hit) gnt_d[winner] = 1'b1;
    if (state_d == StSend) begin
      ch_addr_d = idx_d;
      ch_data_d = str_d[8*idx_d +: 8];
`ifdef STR_LINE_SCHED_SKIP_EN
      ch_valid_d = !(last_ok_q && (ch_data_d == last_q[8*idx_d +: 8]));
`else
      ch_valid_d = 1'b1;
`endif
    end
  end

  // Output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      ch_data_q  <= '0;
      ch_addr_q  <= '0;
      ch_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      ch_data_q  <= ch_data_d;
      ch_addr_q  <= ch_addr_d;
      ch_valid_q <= ch_valid_d;
      done_q     <= done_d;
    end
  end

`ifdef STR_LINE_SCHED_SKIP_EN
  // Shadow of what the line currently shows; trusted once a full string has gone out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q    <= '0;
      last_ok_q <= 1'b0;
    end else begin
      if (state_q == StSend && ch_valid_q && ch_ready) last_q[8*idx_q +: 8] <= ch_data_q;
      if (state_q == StDone) last_ok_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_str_line_sched.sv
// Bench for str_line_sched: driver pushes expected grants/beats from a reference
// model into queues; an independent monitor pops and compares on DUT outputs.
module tb_str_line_sched;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned LEN   = 16;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b0;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*128-1:0]   str_in;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [7:0]             ch_data;
  logic [3:0]             ch_addr;
  logic                   ch_valid;
  logic                   ch_ready = 1'b1;
  logic                   done;

  logic [127:0]           strs [N_REQ];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus controls (written by the driver only)
  logic rdy_rand  = 1'b0;
  logic stall_req = 1'b0;
  logic gap_chk   = 1'b0;

  // Reference model state
  int               model_last_gnt = N_REQ - 1;
  logic [7:0]       m_last [16];
  logic             m_last_ok = 1'b0;

  // Scoreboard
  logic [N_REQ-1:0] exp_gnt [$];
  logic [11:0]      exp_beats [$];
  int               exp_nbeats [$];

  str_line_sched #(.N_REQ(N_REQ), .LEN(LEN)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req),
    .str_in   (str_in),
    .gnt      (gnt),
    .busy     (busy),
    .ch_data  (ch_data),
    .ch_addr  (ch_addr),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .done     (done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always_comb begin
    str_in = '0;
    for (int k = 0; k < N_REQ; k++) str_in[128*k +: 128] = strs[k];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Ready driver: random back-pressure, or a 3-cycle stall when position 5 is offered.
  int stall_seen = 0;
  always @(posedge CLK) begin
    #1;
    if (!stall_req) stall_seen = 0;
    if (rdy_rand) begin
      ch_ready = ($urandom_range(0, 3) != 0);
    end else if (stall_req && ch_valid && ch_addr == 4'd5 && stall_seen < 3) begin
      ch_ready = 1'b0;
      stall_seen++;
    end else begin
      ch_ready = 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant, beat or done.
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = '0;
  logic [3:0] hold_addr = '0;
  logic       done_due  = 1'b0;
  logic       in_string = 1'b0;
  logic       have_done = 1'b0;
  int         beats_seen = 0;
  int         last_done_cyc = 0;

  always @(negedge CLK) begin
    if (RST) begin
      hold_pend  = 1'b0;
      done_due   = 1'b0;
      in_string  = 1'b0;
      have_done  = 1'b0;
      beats_seen = 0;
    end else begin
      if (hold_pend) begin
        chk("held valid", 32'(ch_valid), 32'd1);
        chk("held data", 32'(ch_data), 32'(hold_data));
        chk("held addr", 32'(ch_addr), 32'(hold_addr));
      end
      hold_pend = ch_valid && !ch_ready;
      hold_data = ch_data;
      hold_addr = ch_addr;
`ifndef STR_LINE_SCHED_SKIP_EN
      if (done_due) begin
        chk("done after last beat", 32'(done), 32'd1);
        done_due = 1'b0;
      end
`endif
      if (gnt != '0) begin
        chk("string complete before gnt", 32'(in_string), 32'd0);
        in_string = 1'b1;
        if (exp_gnt.size() == 0) note_fail("gnt", $sformatf("unexpected gnt 0x%0h", gnt));
        else chk("gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
        if (gap_chk && have_done) chk("gnt 2 cycles after done", 32'(cyc - last_done_cyc), 32'd2);
`ifndef STR_LINE_SCHED_SKIP_EN
        chk("valid with gnt", 32'(ch_valid), 32'd1);
`endif
      end
      if (ch_valid && ch_ready) begin
        if (exp_beats.size() == 0)
          note_fail("beat", $sformatf("unexpected beat addr %0d data 0x%0h", ch_addr, ch_data));
        else chk("beat {addr,data}", 32'({ch_addr, ch_data}), 32'(exp_beats.pop_front()));
        beats_seen++;
`ifndef STR_LINE_SCHED_SKIP_EN
        if (ch_addr == 4'(LEN - 1)) done_due = 1'b1;
`endif
      end
      if (done) begin
        if (exp_nbeats.size() == 0) note_fail("done", "unexpected done pulse");
        else chk("beats per string", 32'(beats_seen), 32'(exp_nbeats.pop_front()));
        chk("busy during done", 32'(busy), 32'd1);
        beats_seen    = 0;
        in_string     = 1'b0;
        have_done     = 1'b1;
        last_done_cyc = cyc;
      end
    end
  end

  // Round-robin choice from the rule: first requester at or after last grant + 1.
  function automatic int pick(input logic [N_REQ-1:0] r);
    for (int off = 1; off <= N_REQ; off++) begin
      int k;
      k = (model_last_gnt + off) % N_REQ;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  // Record the grant and the characters requester w is expected to put on the line.
  task automatic model_grant(input int w);
    int n;
    logic [7:0] b;
    n = 0;
    exp_gnt.push_back(N_REQ'(1) << w);
    for (int p = 0; p < LEN; p++) begin
      b = strs[w][8*p +: 8];
`ifdef STR_LINE_SCHED_SKIP_EN
      if (m_last_ok && b == m_last[p]) continue;
      m_last[p] = b;
`endif
      exp_beats.push_back({4'(p), b});
      n++;
    end
    exp_nbeats.push_back(n);
    m_last_ok      = 1'b1;
    model_last_gnt = w;
  endtask

  task automatic model_reset();
    exp_gnt.delete();
    exp_beats.delete();
    exp_nbeats.delete();
    model_last_gnt = N_REQ - 1;
    m_last_ok      = 1'b0;
    for (int p = 0; p < 16; p++) m_last[p] = '0;
  endtask

  task automatic rand_strs();
    for (int k = 0; k < N_REQ; k++)
      for (int p = 0; p < 16; p++) strs[k][8*p +: 8] = 8'($urandom_range(32, 126));
  endtask

  task automatic start_string(input logic [N_REQ-1:0] r);
    bit seen;
    seen = 1'b0;
    model_grant(pick(r));
    req = r;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (gnt != '0) begin
        seen = 1'b1;
        break;
      end
    end
    req = '0;
    if (!seen) note_fail("gnt wait", "no gnt within 20 cycles");
  endtask

  task automatic finish_string();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) note_fail("done wait", "no done within 300 cycles");
  endtask

  task automatic wait_addr(input logic [3:0] a);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ch_valid && ch_addr == a) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!seen) note_fail("addr wait", $sformatf("addr %0d never offered", a));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " gnt"}, 32'(gnt), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " ch_valid"}, 32'(ch_valid), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " ch_data"}, 32'(ch_data), 32'd0);
    chk({tag, " ch_addr"}, 32'(ch_addr), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s;
    int nd;
    bit seen;
    for (int k = 0; k < N_REQ; k++) strs[k] = '0;
    model_reset();

    // Power-on reset
    #2 RST = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Both requesters held: grants alternate, 2 cycles from done to next gnt
    rand_strs();
    for (int i = 0; i < 4; i++) model_grant(pick(2'b11));
    req  = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (gnt != '0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) note_fail("held gnt wait", "no first gnt");
    @(negedge CLK);
    gap_chk = 1'b1;
    nd = 0;
    for (int i = 0; i < 400 && nd < 4; i++) begin
      @(negedge CLK);
      if (done) begin
        nd++;
        if (nd == 4) req = '0;
      end
    end
    req     = '0;
    gap_chk = 1'b0;
    if (nd != 4) note_fail("held done count", $sformatf("saw %0d of 4 dones", nd));
    repeat (4) @(negedge CLK);

    // Fixed string, ready high: first char '1' at addr 0 in the gnt cycle
    s = "0000000000000101";
    strs[0] = s;
    start_string(2'b01);
    chk("t2 first data", 32'(ch_data), 32'h31);
    chk("t2 first addr", 32'(ch_addr), 32'd0);
    finish_string();
    repeat (2) @(negedge CLK);

    // Same string with a 3-cycle stall at addr 5
    stall_req = 1'b1;
    start_string(2'b01);
    finish_string();
    stall_req = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset mid-stream clears every output in the same cycle
    rand_strs();
    start_string(2'b01);
    wait_addr(4'd4);
    RST = 1'b1;
    #1 check_reset_outputs("midreset");
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("busy after reset release", 32'(busy), 32'd0);

    // Reset at addr 7 of requester 1, then both request: requester 0 first, addr 0 restart
    rand_strs();
    start_string(2'b10);
    wait_addr(4'd7);
    RST = 1'b1;
    #1 model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    rand_strs();
    start_string(2'b11);
    finish_string();
    repeat (2) @(negedge CLK);

    // Randomized traffic with random back-pressure
    rdy_rand = 1'b1;
    for (int t = 0; t < 20; t++) begin
      rand_strs();
      start_string(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)));
      finish_string();
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    rdy_rand = 1'b0;
    repeat (2) @(negedge CLK);

`ifdef STR_LINE_SCHED_SKIP_EN
    // Unchanged positions are skipped: only addr 3 goes out on the second pass
    s = "................";
    strs[0] = s;
    start_string(2'b01);
    finish_string();
    repeat (2) @(negedge CLK);
    s[8*3 +: 8] = 8'h31;
    strs[0] = s;
    start_string(2'b01);
    finish_string();
    repeat (2) @(negedge CLK);
`endif

    repeat (4) @(negedge CLK);
    chk("leftover gnt expectations", 32'(exp_gnt.size()), 32'd0);
    chk("leftover beat expectations", 32'(exp_beats.size()), 32'd0);
    chk("leftover done expectations", 32'(exp_nbeats.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
